pwm_duty_meter: RTL and testbench



---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_duty_div.sv | 102 ++++++++++
 rtl/pwm_duty_meter.sv | 186 ++++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions used by the generator and the duty meter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

  typedef enum logic {
    ACQ_WAIT = 1'b0,
    ACQ_RUN  = 1'b1
  } acq_state_e;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  // Duty cycle is carried as whole percent, 0..DUTY_FULL.
  localparam int DUTY_W    = 7;
  localparam int DUTY_FULL = 100;

  // Generator counter limit: duty moves in GEN_STEPS steps of DUTY_STEP percent.
  localparam int GEN_STEPS = 10;
  localparam int DUTY_STEP = DUTY_FULL / GEN_STEPS;

endpackage

// File: rtl/pwm_duty_div.sv
// Serial restoring divider: quotient = floor(h*100/p), one quotient bit per cycle.
// Latency: start accepted in idle, done_o asserted in the 7th busy cycle with quot_o final.
// Backpressure: start_i ignored while busy; abort_i drops to idle with no done_o.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  h_i,
  input  logic [CNT_W-1:0]  p_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DUTY_W-1:0] quot_o,
  output logic [CNT_W-1:0]  h_o,
  output logic [CNT_W-1:0]  p_o
);

  // Dividend h*100 needs CNT_W+7 bits; quotient never exceeds 100 so 7 bits suffice.
  localparam int NW = CNT_W + DUTY_W;

  div_state_e        state_q, state_d;
  logic [NW-1:0]     rem_q, rem_d;
  logic [NW-1:0]     den_q, den_d;
  logic [DUTY_W-1:0] quot_q, quot_d;
  logic [2:0]        iter_q, iter_d;
  logic [CNT_W-1:0]  h_q, h_d;
  logic [CNT_W-1:0]  p_q, p_d;
  logic              ge;

  // Divider state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      den_q   <= '0;
      quot_q  <= '0;
      iter_q  <= '0;
      h_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      quot_q  <= quot_d;
      iter_q  <= iter_d;
      h_q     <= h_d;
      p_q     <= p_d;
    end
  end

  // Latch operands on start, then one restoring step per busy cycle, divisor walking right.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    den_d   = den_q;
    quot_d  = quot_q;
    iter_d  = iter_q;
    h_d     = h_q;
    p_d     = p_q;
    done_o  = 1'b0;
    ge      = (rem_q >= den_q);
    case (state_q)
      DIV_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = DIV_BUSY;
          rem_d   = NW'(h_i) * NW'(DUTY_FULL);
          den_d   = NW'(p_i) << (DUTY_W - 1);
          quot_d  = '0;
          iter_d  = '0;
          h_d     = h_i;
          p_d     = p_i;
        end
      end
      DIV_BUSY: begin
        if (ge) rem_d = rem_q - den_q;
        quot_d = {quot_q[DUTY_W-2:0], ge};
        den_d  = den_q >> 1;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'(DUTY_W - 1)) begin
          state_d = DIV_IDLE;
          done_o  = 1'b1;
        end
        // An abort discards the result even on the final iteration.
        if (abort_i) begin
          state_d = DIV_IDLE;
          done_o  = 1'b0;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign busy_o = (state_q == DIV_BUSY);
  assign quot_o = quot_d;
  assign h_o    = h_q;
  assign p_o    = p_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures PWM period, high time and whole-percent duty from an asynchronous input.
// Latency: 3 clk input sync; result 8 clk after the rise closing a period.
// Backpressure: none; a period closing while the divider is busy is dropped and flagged on overrun.
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  input  logic              clear,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              meas_valid,
  output logic              stuck,
  output logic              overrun
);

  logic              s1_q, s2_q, s3_q;
  logic              rise, fall;
  acq_state_e        acq_q, acq_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic              hi_q, hi_d;
  logic              snap, tmo;
  logic              div_abort, div_busy, div_done;
  logic [DUTY_W-1:0] div_quot;
  logic [CNT_W-1:0]  div_h, div_p;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d;
  logic              stuck_q, stuck_d;
  logic              ovr_q, ovr_d;

  // Two-flop synchroniser plus an edge-detect flop; both edges see the same delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // Acquisition counters, phase flag and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acq_q    <= ACQ_WAIT;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      hi_q     <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      acq_q    <= acq_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      ovr_q    <= ovr_d;
    end
  end

  // Count period and high time between rises; a rise closes the period, a long gap times out.
  always_comb begin
    acq_d  = acq_q;
    pcnt_d = pcnt_q;
    hcnt_d = hcnt_q;
    hi_d   = hi_q;
    snap   = 1'b0;
    tmo    = 1'b0;
    if (clear) begin
      acq_d  = ACQ_WAIT;
      pcnt_d = '0;
      hcnt_d = '0;
      hi_d   = 1'b0;
    end else begin
      case (acq_q)
        ACQ_WAIT: begin
          pcnt_d = '0;
          hcnt_d = '0;
          hi_d   = 1'b0;
          if (rise) begin
            acq_d  = ACQ_RUN;
            pcnt_d = CNT_W'(1);
            hcnt_d = CNT_W'(1);
            hi_d   = 1'b1;
          end
        end
        ACQ_RUN: begin
          if (rise) begin
            snap   = 1'b1;
            pcnt_d = CNT_W'(1);
            hcnt_d = CNT_W'(1);
            hi_d   = 1'b1;
          end else if (pcnt_q == CNT_W'(TIMEOUT)) begin
            tmo    = 1'b1;
            acq_d  = ACQ_WAIT;
            pcnt_d = '0;
            hcnt_d = '0;
            hi_d   = 1'b0;
          end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
            // The fall cycle itself is already low time, so it is not counted as high.
            if (fall) hi_d = 1'b0;
            else if (hi_q) hcnt_d = hcnt_q + CNT_W'(1);
          end
        end
        default: acq_d = ACQ_WAIT;
      endcase
    end
  end

  // A timeout or clear preempts any divide in flight.
  assign div_abort = clear | tmo;

  pwm_duty_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (snap),
    .abort_i (div_abort),
    .h_i     (hcnt_q),
    .p_i     (pcnt_q),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quot_o  (div_quot),
    .h_o     (div_h),
    .p_o     (div_p)
  );

  // Result update: timeout report wins over a divider result; clear only drops stuck.
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    ovr_d    = 1'b0;
    if (clear) begin
      stuck_d = 1'b0;
    end else begin
      if (rise) stuck_d = 1'b0;
      if (tmo) begin
        stuck_d  = 1'b1;
        period_d = '0;
        high_d   = '0;
        duty_d   = s2_q ? DUTY_W'(DUTY_FULL) : '0;
        valid_d  = 1'b1;
      end else if (div_done) begin
        period_d = div_p;
        high_d   = div_h;
        duty_d   = div_quot;
        valid_d  = 1'b1;
      end
      if (snap && div_busy) ovr_d = 1'b1;
    end
  end

  assign period_cnt = period_q;
  assign high_cnt   = high_q;
  assign duty_pct   = duty_q;
  assign meas_valid = valid_q;
  assign stuck      = stuck_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter with a result scoreboard.
// Latency: results expected 10 clk after the driven rise (2 sync + 8 divide).
// Backpressure: overrun pulses counted against a model of divider occupancy.
module tb_pwm_duty_meter;
  import pwm_pkg::*;

  localparam int CNT_W = 16;
  localparam int TMO   = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pwm_in;
  logic              clear;
  logic [CNT_W-1:0]  period_cnt;
  logic [CNT_W-1:0]  high_cnt;
  logic [DUTY_W-1:0] duty_pct;
  logic              meas_valid;
  logic              stuck;
  logic              overrun;

  pwm_duty_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .clear      (clear),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .duty_pct   (duty_pct),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int hi;
    int duty;
    int stk;
  } exp_t;

  exp_t sb[$];
  int   highs[$];
  int   n_chk     = 0;
  int   n_err     = 0;
  int   cyc       = 0;
  int   ovr_seen  = 0;
  int   exp_ovr   = 0;
  int   lat_start = -1;
  int   lat_seen  = -1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every result pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun) ovr_seen++;
      if (meas_valid) begin
        if (lat_start >= 0 && lat_seen < 0) lat_seen = cyc;
        chk("valid_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("period", int'(period_cnt), e.per);
          chk("high", int'(high_cnt), e.hi);
          chk("duty", int'(duty_pct), e.duty);
          chk("stuck", int'(stuck), e.stk);
        end
      end
    end
  end

  task automatic hold(input logic v, input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      pwm_in = v;
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  // Drives n periods of length per (high times from highs[]) plus a closing rise.
  // Divider model: a snapshot is accepted if at least 8 cycles after the last accepted one.
  task automatic train(input int per, input int n, input bit lat);
    int last_acc = -1000;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        int t;
        t = i * per;
        if (t - last_acc >= 8) begin
          sb.push_back('{per, highs[i-1], highs[i-1] * DUTY_FULL / per, 0});
          last_acc = t;
        end else begin
          exp_ovr++;
        end
      end
      @(posedge clk);
      #1 pwm_in = 1'b1;
      if (lat && i == 1) begin
        lat_start = cyc;
        lat_seen  = -1;
      end
      if (i < n) begin
        hold(1'b1, highs[i] - 1);
        hold(1'b0, per - highs[i]);
      end else begin
        hold(1'b0, 1);
      end
    end
    hold(1'b0, 14);
    pulse_clear();
    hold(1'b0, 3);
    chk("sb_drained", sb.size(), 0);
    chk("overruns", ovr_seen, exp_ovr);
    if (lat) begin
      chk("latency", lat_seen - lat_start, 10);
      lat_start = -1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    clear  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_period", int'(period_cnt), 0);
    chk("rst_high", int'(high_cnt), 0);
    chk("rst_duty", int'(duty_pct), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_stuck", int'(stuck), 0);
    chk("rst_overrun", int'(overrun), 0);
    #2 rst_n = 1'b1;
    hold(1'b0, 3);

    // 10-cycle period, 3 high, four results plus first-result latency.
    highs = '{3, 3, 3, 3};
    train(10, 4, 1'b1);

    // Generator-style duty stepping 10% -> 40% -> 10%.
    highs = '{1, 2, 3, 4, 3, 2, 1};
    train(10, 7, 1'b0);

    // Period 7: every other snapshot overruns, duty 28.
    highs = '{2, 2, 2, 2, 2, 2};
    train(7, 6, 1'b0);

    // Timeout with input held high, then a rise clears stuck, then timeout low.
    sb.push_back('{0, 0, DUTY_FULL, 1});
    @(posedge clk);
    #1 pwm_in = 1'b1;
    lat_start = cyc;
    lat_seen  = -1;
    hold(1'b1, TMO + 8);
    chk("tmo_latency", lat_seen - lat_start, TMO + 3);
    lat_start = -1;
    chk("stuck_set", int'(stuck), 1);
    chk("sb_tmo_high", sb.size(), 0);
    hold(1'b0, 4);
    chk("stuck_held", int'(stuck), 1);
    @(posedge clk);
    #1 pwm_in = 1'b1;
    hold(1'b1, 3);
    chk("stuck_clr", int'(stuck), 0);
    sb.push_back('{0, 0, 0, 1});
    hold(1'b0, TMO + 10);
    chk("sb_tmo_low", sb.size(), 0);
    chk("stuck_low", int'(stuck), 1);
    pulse_clear();
    chk("stuck_by_clear", int'(stuck), 0);
    hold(1'b0, 3);

    // Period 3, high 1: floor gives 33.
    highs = '{1, 1, 1, 1};
    train(3, 4, 1'b0);

    // Clear mid-divide: nothing reported, previous results held.
    @(posedge clk);
    #1 pwm_in = 1'b1;
    hold(1'b0, 2);
    @(posedge clk);
    #1 pwm_in = 1'b1;
    hold(1'b0, 4);
    pulse_clear();
    hold(1'b0, 20);
    chk("clr_period", int'(period_cnt), 3);
    chk("clr_high", int'(high_cnt), 1);
    chk("clr_duty", int'(duty_pct), 33);
    chk("clr_overruns", ovr_seen, exp_ovr);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk);
    #1 pwm_in = 1'b1;
    hold(1'b1, 2);
    hold(1'b0, 7);
    @(posedge clk);
    #1 pwm_in = 1'b1;
    hold(1'b1, 2);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_period", int'(period_cnt), 0);
    chk("arst_high", int'(high_cnt), 0);
    chk("arst_duty", int'(duty_pct), 0);
    chk("arst_valid", int'(meas_valid), 0);
    chk("arst_stuck", int'(stuck), 0);
    chk("arst_overrun", int'(overrun), 0);
    pwm_in = 1'b0;
    @(posedge clk);
    #5 rst_n = 1'b1;
    hold(1'b0, 4);
    highs = '{4};
    train(10, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
